// File: rtl/parking_pkg.sv
// ============================================================================
// Module : parking_pkg
// Brief  : Door-state encodings shared by the parking door controller and
//          the code-entry FSM bench.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package parking_pkg;

  localparam int DOOR_STATE_W = 2;

  typedef logic [DOOR_STATE_W-1:0] door_state_t;

  localparam door_state_t ST_CLOSED  = 2'd0;
  localparam door_state_t ST_OPENING = 2'd1;
  localparam door_state_t ST_OPEN    = 2'd2;
  localparam door_state_t ST_CLOSING = 2'd3;

endpackage

`default_nettype wire

// File: rtl/parking_occ_counter.sv
// ============================================================================
// Module : parking_occ_counter
// Brief  : Saturating occupancy counter (0..CAPACITY) with full flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module parking_occ_counter #(
  parameter int CAPACITY = 2,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] occupancy,
  output logic             full
);

  localparam logic [CNT_W-1:0] c_CAP  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] c_ZERO = '0;

  logic [CNT_W-1:0] r_count;

  // Simultaneous inc and dec cancel, so saturation only matters for lone events.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !dec) begin
      if (r_count < c_CAP) r_count <= r_count + 1'b1;
    end else if (dec && !inc) begin
      if (r_count != c_ZERO) r_count <= r_count - 1'b1;
    end
  end

  assign occupancy = r_count;
  assign full      = (r_count == c_CAP);

endmodule

`default_nettype wire

// File: rtl/parking_door_ctrl.sv
// ============================================================================
// Module : parking_door_ctrl
// Brief  : Door motor FSM (open/hold/close, reverse on obstruction) with
//          position and hold timers, plus lot occupancy tracking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module parking_door_ctrl
  import parking_pkg::*;
#(
  parameter int OPEN_TICKS = 4,
  parameter int HOLD_TICKS = 6,
  parameter int CAPACITY   = 2,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             door_open_pulse,
  input  logic             car_pass,
  input  logic             car_exit,
  input  logic             obstruct,
  output logic             motor_open,
  output logic             motor_close,
  output logic             door_is_open,
  output logic [1:0]       door_state,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             denied
);

  localparam int c_POS_W  = $clog2(OPEN_TICKS + 1);
  localparam int c_HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [c_POS_W-1:0]  c_POS_TOP  = c_POS_W'(OPEN_TICKS);
  localparam logic [c_POS_W-1:0]  c_POS_LAST = c_POS_W'(OPEN_TICKS - 1);
  localparam logic [c_POS_W-1:0]  c_POS_ONE  = c_POS_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_END = c_HOLD_W'(HOLD_TICKS - 1);

  door_state_t         r_state;
  door_state_t         w_next_state;
  logic [c_POS_W-1:0]  r_pos;
  logic [c_HOLD_W-1:0] r_hold;
  logic                r_denied;

  logic w_pulse_ok;
  logic w_reverse;
  logic w_open_done;
  logic w_close_done;
  logic w_occ_inc;

  assign w_pulse_ok   = door_open_pulse && !full;
  assign w_reverse    = obstruct || w_pulse_ok;
  // Saturating compare so a reversal caught at the fully-open position still lands in OPEN.
  assign w_open_done  = (r_pos >= c_POS_LAST);
  assign w_close_done = (r_pos <= c_POS_ONE);
  assign w_occ_inc    = (r_state == ST_OPEN) && car_pass;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLOSED;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CLOSED: begin
        if (w_pulse_ok) w_next_state = ST_OPENING;
      end
      ST_OPENING: begin
        if (w_open_done) w_next_state = ST_OPEN;
      end
      ST_OPEN: begin
        if (car_pass)                      w_next_state = ST_CLOSING;
        else if (w_pulse_ok)               w_next_state = ST_OPEN;
        else if (r_hold == c_HOLD_END)     w_next_state = ST_CLOSING;
      end
      ST_CLOSING: begin
        if (w_reverse)         w_next_state = ST_OPENING;
        else if (w_close_done) w_next_state = ST_CLOSED;
      end
      default: w_next_state = ST_CLOSED;
    endcase
  end

  // Output decode of registered state
  always_comb begin
    motor_open   = 1'b0;
    motor_close  = 1'b0;
    door_is_open = 1'b0;
    door_state   = r_state;
    case (r_state)
      ST_OPENING: motor_open   = 1'b1;
      ST_OPEN:    door_is_open = 1'b1;
      ST_CLOSING: motor_close  = 1'b1;
      default:    ;
    endcase
  end

  // Door position; held on the cycle a closing door reverses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
    end else begin
      case (r_state)
        ST_OPENING: r_pos <= w_open_done ? c_POS_TOP : r_pos + 1'b1;
        ST_CLOSING: if (!w_reverse) r_pos <= r_pos - 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == ST_OPEN) begin
      if (w_pulse_ok && !car_pass) r_hold <= '0;
      else                         r_hold <= r_hold + 1'b1;
    end else begin
      r_hold <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_denied <= 1'b0;
    else     r_denied <= door_open_pulse && full &&
                         ((r_state == ST_CLOSED) || (r_state == ST_CLOSING));
  end

  assign denied = r_denied;

  parking_occ_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .inc       (w_occ_inc),
    .dec       (car_exit),
    .occupancy (occupancy),
    .full      (full)
  );

endmodule

`default_nettype wire

// File: tb/tb_parking_door_ctrl.sv
// ============================================================================
// Module : tb_parking_door_ctrl
// Brief  : Directed self-checking bench for parking_door_ctrl (default params).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parking_door_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       door_open_pulse;
  logic       car_pass;
  logic       car_exit;
  logic       obstruct;
  logic       motor_open;
  logic       motor_close;
  logic       door_is_open;
  logic [1:0] door_state;
  logic [2:0] occupancy;
  logic       full;
  logic       denied;

  int n_cmp = 0;
  int n_err = 0;

  parking_door_ctrl #(
    .OPEN_TICKS (4),
    .HOLD_TICKS (6),
    .CAPACITY   (2),
    .CNT_W      (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .door_open_pulse (door_open_pulse),
    .car_pass        (car_pass),
    .car_exit        (car_exit),
    .obstruct        (obstruct),
    .motor_open      (motor_open),
    .motor_close     (motor_close),
    .door_is_open    (door_is_open),
    .door_state      (door_state),
    .occupancy       (occupancy),
    .full            (full),
    .denied          (denied)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_open();
    door_open_pulse = 1'b1;
    step();
    door_open_pulse = 1'b0;
  endtask

  // Packs {motor_open, motor_close, door_is_open, door_state}
  function automatic logic [31:0] door_vec();
    return {27'd0, motor_open, motor_close, door_is_open, door_state};
  endfunction

  function automatic logic [31:0] exp_vec(input int s);
    case (s)
      1:       return 32'b100_01;
      2:       return 32'b001_10;
      3:       return 32'b010_11;
      default: return 32'b000_00;
    endcase
  endfunction

  // Open, car passes on 2nd OPEN cycle, close fully.
  task automatic park_car(input string tag, input int exp_occ);
    pulse_open();
    repeat (4) step();
    chk({tag, "_open"}, door_vec(), exp_vec(2));
    step();
    car_pass = 1'b1;
    step();
    car_pass = 1'b0;
    chk({tag, "_closing"}, door_vec(), exp_vec(3));
    chk({tag, "_occ"}, occupancy, exp_occ);
    repeat (4) step();
    chk({tag, "_closed"}, door_vec(), exp_vec(0));
  endtask

  initial begin
    rst = 1'b1; door_open_pulse = 1'b0; car_pass = 1'b0; car_exit = 1'b0; obstruct = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_door", door_vec(), 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_full", full, 0);
    chk("rst_denied", denied, 0);

    // Exit at empty lot saturates; car_pass while closed is ignored
    car_exit = 1'b1; step(); car_exit = 1'b0;
    chk("exit_at_zero", occupancy, 0);
    car_pass = 1'b1; step(); car_pass = 1'b0;
    chk("pass_closed", occupancy, 0);

    // Full cycle without a car: cycles 1..15
    pulse_open();
    for (int c = 1; c <= 15; c++) begin
      int s;
      s = (c <= 4) ? 1 : (c <= 10) ? 2 : (c <= 14) ? 3 : 0;
      chk($sformatf("cycle_c%0d", c), door_vec(), exp_vec(s));
      if (c < 15) step();
    end
    chk("cycle_occ", occupancy, 0);

    // Two cars fill the lot
    park_car("car1", 1);
    chk("car1_full", full, 0);
    park_car("car2", 2);
    chk("car2_full", full, 1);

    // Refused request while full
    pulse_open();
    chk("deny_pulse", denied, 1);
    chk("deny_door", door_vec(), exp_vec(0));
    step();
    chk("deny_one_cycle", denied, 0);
    chk("deny_still_closed", door_vec(), exp_vec(0));

    car_exit = 1'b1; step(); car_exit = 1'b0;
    chk("exit_occ", occupancy, 1);
    chk("exit_full", full, 0);
    pulse_open();
    chk("reopen", door_vec(), exp_vec(1));

    // Obstruction while closing at pos=2 reopens for 2 cycles
    repeat (4) step();
    chk("obs_open", door_vec(), exp_vec(2));
    repeat (6) step();
    chk("obs_closing", door_vec(), exp_vec(3));
    step(); step();
    obstruct = 1'b1;
    step();
    obstruct = 1'b0;
    chk("obs_rev1", door_vec(), exp_vec(1));
    step();
    chk("obs_rev2", door_vec(), exp_vec(1));
    step();
    chk("obs_reopened", door_vec(), exp_vec(2));

    // Pass and exit together in OPEN: occupancy unchanged, door closes
    step();
    car_pass = 1'b1; car_exit = 1'b1;
    step();
    car_pass = 1'b0; car_exit = 1'b0;
    chk("both_closing", door_vec(), exp_vec(3));
    chk("both_occ", occupancy, 1);
    repeat (4) step();
    chk("both_closed", door_vec(), exp_vec(0));

    // Reset mid-opening abandons motion
    pulse_open();
    step();
    chk("pre_rst_opening", door_vec(), exp_vec(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_door", door_vec(), exp_vec(0));
    chk("midrst_occ", occupancy, 0);
    chk("midrst_full", full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
